// File: rtl/register_bank.sv
// Sixteen-entry architectural register file with a per-register write-pending scoreboard.
// Optional macro REGBANK_BYPASS_EN forwards the write-back value to rN and busy in the same cycle.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             claim_en,
  input  logic [3:0]       claim_addr,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15,
  output logic [NREGS-1:0] busy,
  output logic             wr_ack
);

  // Strobe semantics: wr_en and claim_en are valid-only strobes with no ready;
  // every strobe sampled on a rising edge is accepted, there is no back-pressure.

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd   [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] claim_hit;
  logic [NREGS-1:0] busy_q;

  always_comb begin
    wr_hit    = '0;
    claim_hit = '0;
    if (wr_en)    wr_hit[wr_addr]       = 1'b1;
    if (claim_en) claim_hit[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_hit[i]) regs[i] <= wr_data;
      end
    end
  end

  // A new claim landing on the same cycle as the retiring write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      wr_ack <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~wr_hit) | claim_hit;
      wr_ack <= wr_en;
    end
  end

`ifdef REGBANK_BYPASS_EN
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rd[i] = wr_hit[i] ? wr_data : regs[i];
    end
    busy = busy_q & ~(wr_hit & ~claim_hit);
  end
`else
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rd[i] = regs[i];
    end
    busy = busy_q;
  end
`endif

  assign r0  = rd[0];
  assign r1  = rd[1];
  assign r2  = rd[2];
  assign r3  = rd[3];
  assign r4  = rd[4];
  assign r5  = rd[5];
  assign r6  = rd[6];
  assign r7  = rd[7];
  assign r8  = rd[8];
  assign r9  = rd[9];
  assign r10 = rd[10];
  assign r11 = rd[11];
  assign r12 = rd[12];
  assign r13 = rd[13];
  assign r14 = rd[14];
  assign r15 = rd[15];

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset, sequential write-back, scoreboard and async reset.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_addr;
  logic [15:0] r [16];
  logic [15:0] busy;
  logic        wr_ack;

  int n_cmp;
  int n_bad;
  logic [15:0] exp_r [16];
  logic [15:0] exp_q [$];

  register_bank dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .busy(busy), .wr_ack(wr_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    claim_en = 1'b0; claim_addr = '0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (r[i] !== 16'h0000) begin
        n_bad++; $display("FAIL reset_r%0d: got %h want 0000", i, r[i]);
      end
    end
    n_cmp++;
    if (busy !== 16'h0000) begin n_bad++; $display("FAIL reset_busy: got %h want 0000", busy); end
    n_cmp++;
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (r[5] !== 16'hBEEF) begin n_bad++; $display("FAIL first_write_r5: got %h want beef", r[5]); end
    n_cmp++;
    if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL first_write_ack: got %b want 1", wr_ack); end
    wr_en = 1'b0;
    tick();
    n_cmp++;
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL ack_drop: got %b want 0", wr_ack); end
  endtask

  task automatic test_sequential_writes();
    do_reset();
    for (int n = 0; n < 16; n++) begin
      wr_en = 1'b1; wr_addr = 4'(n); wr_data = 16'h1000 + 16'(n);
      exp_q.push_back(16'h1000 + 16'(n));
      tick();
      exp_r[n] = exp_q.pop_front();
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (r[i] !== exp_r[i]) begin
          n_bad++; $display("FAIL seq_step%0d_r%0d: got %h want %h", n, i, r[i], exp_r[i]);
        end
      end
      n_cmp++;
      if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL seq_ack%0d: got %b want 1", n, wr_ack); end
    end
    idle();
    tick();
  endtask

  task automatic test_claim_then_write();
    do_reset();
    claim_en = 1'b1; claim_addr = 4'd3;
    tick();
    claim_en = 1'b0;
    n_cmp++;
    if (busy !== 16'h0008) begin n_bad++; $display("FAIL claim_busy_c1: got %h want 0008", busy); end
    tick();
    n_cmp++;
    if (busy !== 16'h0008) begin n_bad++; $display("FAIL claim_busy_c2: got %h want 0008", busy); end
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00A5;
    tick();
    idle();
    n_cmp++;
    if (busy !== 16'h0000) begin n_bad++; $display("FAIL retire_busy: got %h want 0000", busy); end
    n_cmp++;
    if (r[3] !== 16'h00A5) begin n_bad++; $display("FAIL retire_r3: got %h want 00a5", r[3]); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    claim_en = 1'b1; claim_addr = 4'd7;
    tick();
    claim_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
    tick();
    n_cmp++;
    if (busy !== 16'h0080) begin n_bad++; $display("FAIL set_dominates_busy: got %h want 0080", busy); end
    n_cmp++;
    if (r[7] !== 16'h7777) begin n_bad++; $display("FAIL set_dominates_r7: got %h want 7777", r[7]); end
    claim_addr = 4'd9; wr_en = 1'b0;
    tick();
    claim_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909;
    tick();
    idle();
    n_cmp++;
    if (busy !== 16'h0084) begin n_bad++; $display("FAIL split_busy: got %h want 0084", busy); end
    n_cmp++;
    if (r[9] !== 16'h0909) begin n_bad++; $display("FAIL split_r9: got %h want 0909", r[9]); end
    // write to a non-busy register: data lands, busy bit stays clear
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
    tick();
    idle();
    n_cmp++;
    if (busy !== 16'h0084) begin n_bad++; $display("FAIL idle_write_busy: got %h want 0084", busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h7FFF;
    claim_en = 1'b1; claim_addr = 4'd10;
    tick();
    wr_en = 1'b0; claim_addr = 4'd0;
    tick();
    claim_en = 1'b0;
    n_cmp++;
    if (busy !== 16'h0401 || r[10] !== 16'h7FFF) begin
      n_bad++; $display("FAIL pre_reset_state: got busy %h r10 %h want 0401 7fff", busy, r[10]);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (r[10] !== 16'h0000) begin n_bad++; $display("FAIL async_r10: got %h want 0000", r[10]); end
    n_cmp++;
    if (busy !== 16'h0000) begin n_bad++; $display("FAIL async_busy: got %h want 0000", busy); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'hAAAA;
    tick();
    wr_data = 16'h1234;
    #1;
    n_cmp++;
`ifdef REGBANK_BYPASS_EN
    if (r[12] !== 16'h1234) begin n_bad++; $display("FAIL bypass_r12: got %h want 1234", r[12]); end
`else
    if (r[12] !== 16'hAAAA) begin n_bad++; $display("FAIL nobypass_r12: got %h want aaaa", r[12]); end
`endif
    tick();
    idle();
    n_cmp++;
    if (r[12] !== 16'h1234) begin n_bad++; $display("FAIL post_edge_r12: got %h want 1234", r[12]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_sequential_writes();
    test_claim_then_write();
    test_same_cycle();
    test_async_reset();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
